// File: rtl/pc_unit.sv
// pc_unit: program-counter register and next-PC selector for the fetch stage
// Optional feature macro: PC_JR_EN adds the jr/jr_addr jump-register redirect.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   B, J                PC+1 and PC[29:26] fed back from the fetch unit
//   stall               hold PC this cycle
//   br_taken, br_imm    branch redirect, signed word offset from B
//   jump, jump_target   absolute jump within the current region
//   jr, jr_addr         jump-register redirect (PC_JR_EN only)
//   halt                stop fetching until reset
//   PC                  current fetch word address
//   pc_valid            PC is a real fetch this cycle
//   redirect_pending    a redirect is buffered awaiting stall release
module pc_unit #(
    parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] B,
    input  logic [3:0]  J,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
`ifdef PC_JR_EN
    input  logic        jr,
    input  logic [31:0] jr_addr,
`endif
    input  logic        halt,
    output logic [29:0] PC,
    output logic        pc_valid,
    output logic        redirect_pending
);
    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HLT  = 2'd2;

    logic [1:0]  state;
    logic [29:0] tgt, ptgt;
    logic        redir;

`ifdef PC_JR_EN
    logic unused_jr;
    assign unused_jr = ^jr_addr[1:0];
    assign redir = jr | jump | br_taken;
    assign tgt = jr ? jr_addr[31:2] :
                 jump ? {J, jump_target} :
                 br_taken ? B + {{14{br_imm[15]}}, br_imm} : B;
`else
    assign redir = jump | br_taken;
    assign tgt = jump ? {J, jump_target} :
                 br_taken ? B + {{14{br_imm[15]}}, br_imm} : B;
`endif

    assign pc_valid = state == RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC               <= RESET_PC;
            state            <= BOOT;
            redirect_pending <= 1'b0;
            ptgt             <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (!stall) begin
                        // halt beats any redirect and drops a buffered one
                        if (halt) begin
                            state            <= HLT;
                            redirect_pending <= 1'b0;
                        end else if (redirect_pending) begin
                            // buffered redirect is from an older instruction
                            PC               <= ptgt;
                            redirect_pending <= 1'b0;
                        end else begin
                            PC <= tgt;
                        end
                    end else if (redir && !redirect_pending) begin
                        ptgt             <= tgt;
                        redirect_pending <= 1'b1;
                    end
                end
                default: state <= HLT;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [29:0] b;
    logic [3:0]  j;
    logic        stall = 1'b0, br_taken = 1'b0, jump = 1'b0, halt = 1'b0;
    logic [15:0] br_imm = '0;
    logic [25:0] jump_target = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_addr = '0;
    logic [29:0] pc;
    logic        pc_valid, redirect_pending;
    logic        jo = 1'b0;
    logic [3:0]  jv = '0;

    typedef struct packed {
        logic [29:0] pc;
        logic        v;
        logic        p;
    } exp_t;

    exp_t q[$];
    int   vec = 0;
    int   err = 0;

    assign b = pc + 30'd1;
    assign j = jo ? jv : pc[29:26];

    always #5 clk = ~clk;

    pc_unit #(.RESET_PC(30'h0000_0C00)) dut (
        .clk(clk),
        .rst(rst),
        .B(b),
        .J(j),
        .stall(stall),
        .br_taken(br_taken),
        .br_imm(br_imm),
        .jump(jump),
        .jump_target(jump_target),
`ifdef PC_JR_EN
        .jr(jr),
        .jr_addr(jr_addr),
`endif
        .halt(halt),
        .PC(pc),
        .pc_valid(pc_valid),
        .redirect_pending(redirect_pending)
    );

    task automatic cmp(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            err++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = q.pop_front();
            vec++;
            assert (pc === e.pc && pc_valid === e.v && redirect_pending === e.p)
            else begin
                err++;
                $error("FAIL %s: pc=%h valid=%b pend=%b, expected pc=%h valid=%b pend=%b",
                       tag, pc, pc_valid, redirect_pending, e.pc, e.v, e.p);
            end
        end
    endtask

    task automatic now(input string tag, input logic [29:0] epc, input logic ev, input logic ep);
        q.push_back({epc, ev, ep});
        cmp(tag);
    endtask

    task automatic step(input string tag, input logic [29:0] epc, input logic ev, input logic ep);
        q.push_back({epc, ev, ep});
        @(posedge clk);
        #1;
        cmp(tag);
    endtask

    task automatic idle();
        stall = 1'b0; br_taken = 1'b0; jump = 1'b0; halt = 1'b0; jr = 1'b0; jo = 1'b0;
    endtask

    initial begin
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        now("reset", 30'h0C00, 1'b0, 1'b0);
        step("boot", 30'h0C00, 1'b1, 1'b0);
        step("seq1", 30'h0C01, 1'b1, 1'b0);
        step("seq2", 30'h0C02, 1'b1, 1'b0);

        jump = 1'b1; jump_target = 26'h10;
        step("jmp10", 30'h0010, 1'b1, 1'b0);
        idle(); br_taken = 1'b1; br_imm = 16'hFFFE;
        step("br_neg", 30'h000F, 1'b1, 1'b0);
        idle(); jump = 1'b1; jump_target = 26'h0;
        step("jmp0", 30'h0000, 1'b1, 1'b0);
        idle(); br_taken = 1'b1; br_imm = 16'h8000;
        step("br_wrap", 30'h3FFF_8001, 1'b1, 1'b0);

        idle(); jo = 1'b1; jv = 4'h8; jump = 1'b1; jump_target = 26'h0000123;
        br_taken = 1'b1; br_imm = 16'h0004;
        step("jmp_over_br", 30'h2000_0123, 1'b1, 1'b0);
        idle(); jo = 1'b1; jv = 4'h0; jump = 1'b1; jump_target = 26'h40;
        step("jmp40", 30'h0040, 1'b1, 1'b0);

        idle(); stall = 1'b1; jump = 1'b1; jump_target = 26'h100;
        step("stall1", 30'h0040, 1'b1, 1'b1);
        jump = 1'b0; br_taken = 1'b1; br_imm = 16'h0005;
        step("stall2", 30'h0040, 1'b1, 1'b1);
        br_taken = 1'b0;
        step("stall3", 30'h0040, 1'b1, 1'b1);
        idle();
        step("release", 30'h0100, 1'b1, 1'b0);
        step("after_rel", 30'h0101, 1'b1, 1'b0);

        stall = 1'b1; br_taken = 1'b1; br_imm = 16'h0003;
        step("stall_br", 30'h0101, 1'b1, 1'b1);
        idle(); jump = 1'b1; jump_target = 26'h300;
        step("pend_wins", 30'h0105, 1'b1, 1'b0);

        idle(); jump = 1'b1; jump_target = 26'h20;
        step("jmp20", 30'h0020, 1'b1, 1'b0);
        idle(); stall = 1'b1; halt = 1'b1; jump = 1'b1; jump_target = 26'h80;
        step("halt_stalled", 30'h0020, 1'b1, 1'b1);
        stall = 1'b0;
        step("halt", 30'h0020, 1'b0, 1'b0);
        idle();
        step("halted1", 30'h0020, 1'b0, 1'b0);
        step("halted2", 30'h0020, 1'b0, 1'b0);

        #2 rst = 1'b1;
        #1 rst = 1'b0;
        now("reset2", 30'h0C00, 1'b0, 1'b0);
        step("boot2", 30'h0C00, 1'b1, 1'b0);
        step("seq3", 30'h0C01, 1'b1, 1'b0);
        stall = 1'b1; jump = 1'b1; jump_target = 26'h200;
        step("pend_set", 30'h0C01, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        now("async_rst", 30'h0C00, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        step("boot3", 30'h0C00, 1'b1, 1'b0);
        step("no_pend_after_rst", 30'h0C01, 1'b1, 1'b0);

`ifdef PC_JR_EN
        jr = 1'b1; jr_addr = 32'h0000_3004; jump = 1'b1; jump_target = 26'h55;
        step("jr_top", 30'h0C01, 1'b1, 1'b0);
        idle();
        step("after_jr", 30'h0C02, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
